// File: rtl/voice_pipeline.sv
// Polyphonic voice allocator, per-voice ADSR envelope and three-stage mixer.
// Sits between the MIDI decoder and the DAC; the per-voice oscillators live
// outside and are fed through voice_note / voice_clear.

package MIDI;
    localparam logic STATUS_OFF = 1'b0;
    localparam logic STATUS_ON  = 1'b1;

    typedef struct packed {
        logic       status;
        logic [6:0] note_number;
        logic [6:0] velocity;
    } note_change_t;
endpackage

module voice_pipeline #(
    parameter int NUM_VOICES      = 4,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int DATA_WIDTH      = 7,
    parameter int ENV_WIDTH       = 16,
    parameter int TICK_DIV        = 500
) (
    input  logic                                  clock_50_000_000,
    input  logic                                  reset_l,
    // note is sampled on every cycle where note_ready is high; there is no
    // back-pressure, so one event per cycle is always accepted.
    input  MIDI::note_change_t                    note,
    input  logic                                  note_ready,
    input  logic [ENV_WIDTH-1:0]                  attack_step,
    input  logic [ENV_WIDTH-1:0]                  decay_step,
    input  logic [ENV_WIDTH-1:0]                  release_step,
    input  logic [ENV_WIDTH-1:0]                  sustain_level,
    input  logic [NUM_VOICES*AUDIO_BIT_WIDTH-1:0] voice_wave,
    output logic [NUM_VOICES*DATA_WIDTH-1:0]      voice_note,
    output logic [NUM_VOICES-1:0]                 voice_clear,
    output logic [NUM_VOICES-1:0]                 voice_active,
    output logic [AUDIO_BIT_WIDTH-1:0]            audio,
    output logic [3*NUM_VOICES-1:0]               voice_state_dbg
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = AUDIO_BIT_WIDTH + ENV_WIDTH;
    localparam int GW = AUDIO_BIT_WIDTH + DATA_WIDTH + 1;
    localparam int SW = AUDIO_BIT_WIDTH + VW;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    logic [CW-1:0]              tick_cnt_q;
    logic                       tick;

    logic [2:0]                 state_q [NUM_VOICES];
    logic [2:0]                 state_d [NUM_VOICES];
    logic [ENV_WIDTH-1:0]       level_q [NUM_VOICES];
    logic [ENV_WIDTH-1:0]       level_d [NUM_VOICES];
    logic [DATA_WIDTH-1:0]      note_q  [NUM_VOICES];
    logic [DATA_WIDTH-1:0]      note_d  [NUM_VOICES];
    logic [DATA_WIDTH-1:0]      vel_q   [NUM_VOICES];
    logic [DATA_WIDTH-1:0]      vel_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0]      clear_q, clear_d;
    logic [VW-1:0]              steal_q, steal_d;

    logic                       ev_on, ev_off;
    logic [DATA_WIDTH-1:0]      ev_note, ev_vel;
    logic                       hit_found, idle_found, rel_found;
    logic [VW-1:0]              hit_idx, idle_idx, rel_idx;
    logic [VW-1:0]              alloc_idx;
    logic                       alloc_keep;

    logic [PW-1:0]              prod1   [NUM_VOICES];
    logic [GW-1:0]              prod2   [NUM_VOICES];
    logic [AUDIO_BIT_WIDTH-1:0] p_d     [NUM_VOICES];
    logic [AUDIO_BIT_WIDTH-1:0] p_q     [NUM_VOICES];
    logic [DATA_WIDTH-1:0]      pv_q    [NUM_VOICES];
    logic [AUDIO_BIT_WIDTH-1:0] g_d     [NUM_VOICES];
    logic [AUDIO_BIT_WIDTH-1:0] g_q     [NUM_VOICES];
    logic [SW-1:0]              mix_sum;
    logic [AUDIO_BIT_WIDTH-1:0] audio_d, audio_q;

    assign tick    = (tick_cnt_q == CW'(TICK_DIV - 1));
    assign ev_on   = note_ready && (note.status == MIDI::STATUS_ON);
    assign ev_off  = note_ready && (note.status == MIDI::STATUS_OFF);
    assign ev_note = DATA_WIDTH'(note.note_number);
    assign ev_vel  = DATA_WIDTH'(note.velocity);

    // Free-running envelope tick divider.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Pick the voice for a note-on: retrigger, then idle, then releasing, then steal.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        rel_found  = 1'b0;
        rel_idx    = '0;
        // Scan downwards so the lowest matching index is the one kept.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (state_q[v] != ST_IDLE && note_q[v] == ev_note) begin
                hit_found = 1'b1;
                hit_idx   = VW'(v);
            end
            if (state_q[v] == ST_IDLE) begin
                idle_found = 1'b1;
                idle_idx   = VW'(v);
            end
            if (state_q[v] == ST_RELEASE) begin
                rel_found = 1'b1;
                rel_idx   = VW'(v);
            end
        end
        alloc_idx  = steal_q;
        alloc_keep = 1'b0;
        steal_d    = steal_q;
        if (hit_found) begin
            alloc_idx  = hit_idx;
            alloc_keep = 1'b1;
        end else if (idle_found) begin
            alloc_idx = idle_idx;
        end else if (rel_found) begin
            alloc_idx = rel_idx;
        end else if (ev_on) begin
            // Power-of-two voice count makes the natural wrap the modulo.
            steal_d = steal_q + 1'b1;
        end
    end

    // Per-voice next state: an event on a voice overrides that voice's tick.
    always_comb begin
        clear_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            level_d[v] = level_q[v];
            note_d[v]  = note_q[v];
            vel_d[v]   = vel_q[v];
            if (ev_on && alloc_idx == VW'(v)) begin
                state_d[v] = ST_ATTACK;
                note_d[v]  = ev_note;
                vel_d[v]   = ev_vel;
                clear_d[v] = 1'b1;
                if (!alloc_keep) begin
                    level_d[v] = '0;
                end
            end else if (ev_off && note_q[v] == ev_note &&
                         (state_q[v] == ST_ATTACK || state_q[v] == ST_DECAY ||
                          state_q[v] == ST_SUSTAIN)) begin
                state_d[v] = ST_RELEASE;
            end else if (tick) begin
                case (state_q[v])
                    ST_ATTACK: begin
                        if (attack_step == '0 ||
                            ({1'b0, level_q[v]} + {1'b0, attack_step}) >= {1'b0, ENV_MAX}) begin
                            level_d[v] = ENV_MAX;
                            state_d[v] = ST_DECAY;
                        end else begin
                            level_d[v] = level_q[v] + attack_step;
                        end
                    end
                    ST_DECAY: begin
                        if (sustain_level >= level_q[v]) begin
                            state_d[v] = ST_SUSTAIN;
                        end else if (level_q[v] - sustain_level <= decay_step) begin
                            level_d[v] = sustain_level;
                            state_d[v] = ST_SUSTAIN;
                        end else begin
                            level_d[v] = level_q[v] - decay_step;
                        end
                    end
                    ST_RELEASE: begin
                        if (level_q[v] <= release_step) begin
                            level_d[v] = '0;
                            state_d[v] = ST_IDLE;
                        end else begin
                            level_d[v] = level_q[v] - release_step;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Voice registers, clear pulses and steal pointer.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                level_q[v] <= '0;
                note_q[v]  <= '0;
                vel_q[v]   <= '0;
            end
            clear_q <= '0;
            steal_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                level_q[v] <= level_d[v];
                note_q[v]  <= note_d[v];
                vel_q[v]   <= vel_d[v];
            end
            clear_q <= clear_d;
            steal_q <= steal_d;
        end
    end

    // Mixer arithmetic: envelope gain, velocity gain, then average of voices.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            prod1[v] = PW'(voice_wave[v*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) * PW'(level_q[v]);
            p_d[v]   = (state_q[v] == ST_IDLE) ? '0 : AUDIO_BIT_WIDTH'(prod1[v] >> ENV_WIDTH);
            prod2[v] = GW'(p_q[v]) * (GW'(pv_q[v]) + GW'(1));
            g_d[v]   = AUDIO_BIT_WIDTH'(prod2[v] >> DATA_WIDTH);
            mix_sum  = mix_sum + SW'(g_q[v]);
        end
        audio_d = AUDIO_BIT_WIDTH'(mix_sum >> VW);
    end

    // Three pipeline stages; velocity travels with its S1 product.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                p_q[v]  <= '0;
                pv_q[v] <= '0;
                g_q[v]  <= '0;
            end
            audio_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                p_q[v]  <= p_d[v];
                pv_q[v] <= vel_q[v];
                g_q[v]  <= g_d[v];
            end
            audio_q <= audio_d;
        end
    end

    // Flatten per-voice registers onto the output buses.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[v*DATA_WIDTH +: DATA_WIDTH] = note_q[v];
            voice_active[v]                        = (state_q[v] != ST_IDLE);
            voice_state_dbg[v*3 +: 3]              = state_q[v];
        end
    end

    assign voice_clear = clear_q;
    assign audio       = audio_q;

endmodule

// File: doc/voice_pipeline.md
# voice_pipeline

Polyphonic successor to the single-voice audio pipeline. Allocates incoming MIDI note events to `NUM_VOICES` voices, runs a per-voice ADSR envelope with velocity scaling, and mixes all voices into one unsigned audio sample. It sits between the MIDI decoder and the DAC. Per-voice oscillators and the period lookup stay outside: this block drives `voice_note`/`voice_clear` to them and takes their `voice_wave` samples back.

## Interface
- `NUM_VOICES`, 4: voice count; power of two, ≥2.
- `AUDIO_BIT_WIDTH`, 16: unsigned sample width.
- `DATA_WIDTH`, 7: MIDI note and velocity width.
- `ENV_WIDTH`, 16: envelope level width; max level is all-ones.
- `TICK_DIV`, 500: clock cycles per envelope tick; ≥2.

Ports:
- `clock_50_000_000`  in  1: system clock.
- `reset_l`  in  1: asynchronous, active-low reset.
- `note`  in  MIDI::note_change_t: status (ON/OFF), note_number, velocity.
- `note_ready`  in  1: one-cycle strobe; `note` is valid while it is high.
- `attack_step`, `decay_step`, `release_step`  in  ENV_WIDTH each: level delta per tick.
- `sustain_level`  in  ENV_WIDTH: decay floor.
- `voice_wave`  in  NUM_VOICES×AUDIO_BIT_WIDTH: oscillator samples.
- `voice_note`  out  NUM_VOICES×DATA_WIDTH: note assigned to each voice.
- `voice_clear`  out  NUM_VOICES: one-cycle phase-reset pulse per voice.
- `voice_active`  out  NUM_VOICES: voice state ≠ IDLE.
- `audio`  out  AUDIO_BIT_WIDTH: mixed output.

## Operation
- Per-voice state: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Each voice also holds `level`, `note`, and `velocity`.
- Tick: a free-running counter from 0 to TICK_DIV-1. `tick` is high for the one cycle when the counter equals TICK_DIV-1. Envelopes advance only on `tick`.
- ATTACK: `level` += `attack_step`, saturating at max. On reaching max, go to DECAY. An `attack_step` of 0 sets `level` to max immediately on the next tick.
- DECAY: `level` -= `decay_step`, floored at `sustain_level`. On reaching it, go to SUSTAIN. If `sustain_level` is at or above `level`, go to SUSTAIN with `level` unchanged.
- SUSTAIN: hold `level`.
- RELEASE: `level` -= `release_step`, floored at 0. On reaching 0, go to IDLE.
- Note ON allocation, first match wins:
  1. A non-IDLE voice already holding the same note: retrigger it.
  2. Lowest-index IDLE voice.
  3. Lowest-index voice in RELEASE.
  4. The voice at `steal_ptr`, after which `steal_ptr` increments mod NUM_VOICES.
- Effect of allocation or retrigger on the chosen voice:
  - Latch `note` and `velocity`; enter ATTACK.
  - Retrigger keeps the current `level`. A fresh or stolen voice sets `level` to 0.
  - Pulse `voice_clear[v]` for one cycle.
- Note OFF: every voice with a matching note in ATTACK, DECAY or SUSTAIN enters RELEASE with `level` kept. No match: no effect. OFF on a voice already in RELEASE: no effect.
- An event and a tick in the same cycle: the event wins for the addressed voice(s). All other voices take the tick.
- Datapath, 3 registered stages:
  - S1: `p[v] = (voice_wave[v] * level[v]) >> ENV_WIDTH`
  - S2: `g[v] = (p[v] * (velocity[v] + 1)) >> DATA_WIDTH`
  - S3: `audio = (Σ g[v]) >> log2(NUM_VOICES)`
  - Accumulator width is AUDIO_BIT_WIDTH + log2(NUM_VOICES). No overflow is possible.
- IDLE voices contribute 0 regardless of `voice_wave`.

## Timing
- Reset, asynchronous and immediate:
  - All voices IDLE; `level`, `note` and `velocity` 0.
  - `steal_ptr` 0; tick counter 0.
  - `audio`, `voice_clear`, `voice_active` and `voice_note` all 0.
- Event latency: `note_ready` at cycle N → state, `voice_note`, `voice_active` and the `voice_clear` pulse all registered and visible at N+1.
- Audio latency: a `level` or `voice_wave` change at cycle N appears on `audio` at N+3.
- Event acceptance: `note_ready` may assert every cycle, and every event is accepted. Back-to-back ON events allocate against the state updated by the previous event.
- A voice reaching IDLE from RELEASE at tick cycle N is allocatable by an event at N+1.
- Reset deasserting mid-note: the block restarts silent, with no residual pulses.

## Test plan
All scenarios use NUM_VOICES=4, TICK_DIV=4, AUDIO_BIT_WIDTH=16, ENV_WIDTH=16, and `voice_wave` all 0xFFFF unless noted.
- Reset: hold `reset_l`=0 for 3 cycles, then release → `audio`=0, `voice_active`=0, `voice_clear`=0, tick counter restarts at 0.
- Attack/decay: ON note 60 velocity 127 with `attack_step`=0x4000 → `voice_clear`=0001 for one cycle and `voice_note[0]`=60. After 4 ticks `level`=0xFFFF and `audio`=0x3FFF. Then with `decay_step`=0x1000 and `sustain_level`=0x8000 → reaches SUSTAIN at 0x8000, `audio`=0x1FFF.
- Release: in SUSTAIN at 0x8000, send OFF note 60 with `release_step`=0x1000 → IDLE after 8 ticks (32 cycles), `voice_active[0]`=0, `audio`=0 three cycles later.
- Steal: ON notes 60, 62, 64, 65 (all sustaining), then ON note 67 → voice 0 is stolen, `voice_note[0]`=67, `level[0]`=0, `voice_clear`=0001. A further ON note 69 steals voice 1.
- Retrigger and concurrency: ON note 60 twice in back-to-back cycles → voice 0 only, `voice_active`=0001, two `voice_clear[0]` pulses, second velocity latched. An ON on a tick cycle → the addressed voice starts ATTACK from 0 while the other voices advance.
- Mid-operation reset: assert `reset_l`=0 during RELEASE → `audio` and `voice_active` are 0 within the same cycle, asynchronously.
